// File: rtl/ofmap_packer.sv
// ofmap_packer: buffers four per-kernel psum streams in small FIFOs and packs
// one value per kernel into a word {kn3,kn2,kn1,kn0} on a valid/ready stream.
// A programmable word count frames each output feature map (o_last, o_done).
// Optional build macro: OFMAP_PACKER_RELU_EN clamps negative psums to zero at
// FIFO write time.
module ofmap_packer #(
    parameter int BIT_WIDTH  = 8,
    parameter int NUM_KERNEL = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [BIT_WIDTH-1:0]            i_psum_kn0,
    input  logic [BIT_WIDTH-1:0]            i_psum_kn1,
    input  logic [BIT_WIDTH-1:0]            i_psum_kn2,
    input  logic [BIT_WIDTH-1:0]            i_psum_kn3,
    input  logic                            i_psum_kn0_val,
    input  logic                            i_psum_kn1_val,
    input  logic                            i_psum_kn2_val,
    input  logic                            i_psum_kn3_val,
    input  logic                            i_start,
    input  logic [CNT_WIDTH-1:0]            i_conf_npix,
    output logic [BIT_WIDTH*NUM_KERNEL-1:0] o_data,
    output logic                            o_data_val,
    input  logic                            i_data_rdy,
    output logic                            o_last,
    output logic                            o_done,
    output logic                            o_busy,
    output logic [NUM_KERNEL-1:0]           o_overflow
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state_reg, state_next;

    logic [BIT_WIDTH-1:0]            psum_in   [NUM_KERNEL];
    logic [NUM_KERNEL-1:0]           psum_val;
    logic [BIT_WIDTH-1:0]            head_data [NUM_KERNEL];
    logic [NUM_KERNEL-1:0]           nonempty;
    logic [NUM_KERNEL-1:0]           overflow_reg;
    logic [BIT_WIDTH*NUM_KERNEL-1:0] packed_word;

    logic                            pop;
    logic                            frame_start;
    logic [CNT_WIDTH-1:0]            npix_reg;
    logic [CNT_WIDTH-1:0]            cnt_reg;
    logic [CNT_WIDTH-1:0]            cnt_inc;
    logic [BIT_WIDTH*NUM_KERNEL-1:0] data_reg;
    logic                            val_reg;
    logic                            last_reg;

    assign psum_in[0] = i_psum_kn0;
    assign psum_in[1] = i_psum_kn1;
    assign psum_in[2] = i_psum_kn2;
    assign psum_in[3] = i_psum_kn3;
    assign psum_val   = {i_psum_kn3_val, i_psum_kn2_val, i_psum_kn1_val, i_psum_kn0_val};

    generate
        for (genvar gi = 0; gi < NUM_KERNEL; gi++) begin : g_fifo
            logic [BIT_WIDTH-1:0] mem [FIFO_DEPTH];
            logic [PW-1:0]        wr_ptr_reg;
            logic [PW-1:0]        rd_ptr_reg;
            logic [CW-1:0]        count_reg;
            logic [BIT_WIDTH-1:0] wr_data;
            logic                 full;
            logic                 wr_en;

`ifdef OFMAP_PACKER_RELU_EN
            assign wr_data = psum_in[gi][BIT_WIDTH-1] ? '0 : psum_in[gi];
`else
            assign wr_data = psum_in[gi];
`endif
            assign full          = (count_reg == DEPTH_C);
            assign nonempty[gi]  = (count_reg != '0);
            // A full FIFO still takes a write when the same cycle pops a slot.
            assign wr_en         = psum_val[gi] && (!full || pop);
            assign head_data[gi] = mem[rd_ptr_reg];
            assign packed_word[gi*BIT_WIDTH +: BIT_WIDTH] = head_data[gi];

            // Storage array: write only, no reset so it maps onto plain RAM.
            always_ff @(posedge clk) begin
                if (wr_en)
                    mem[wr_ptr_reg] <= wr_data;
            end

            // Pointer and occupancy bookkeeping; pointers wrap naturally.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (wr_en)
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (pop)
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    if (wr_en && !pop)
                        count_reg <= count_reg + 1'b1;
                    else if (!wr_en && pop)
                        count_reg <= count_reg - 1'b1;
                end
            end

            // Sticky drop flag, cleared when a new frame starts.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    overflow_reg[gi] <= 1'b0;
                else if (frame_start)
                    overflow_reg[gi] <= 1'b0;
                else if (psum_val[gi] && full && !pop)
                    overflow_reg[gi] <= 1'b1;
            end
        end
    endgenerate

    assign cnt_inc = cnt_reg + 1'b1;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next state, frame start and pop decision.
    always_comb begin
        state_next  = state_reg;
        pop         = 1'b0;
        frame_start = 1'b0;
        case (state_reg)
            IDLE: begin
                if (i_start) begin
                    frame_start = 1'b1;
                    state_next  = (i_conf_npix == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // Once the last word is loaded no more pops until the next frame.
                pop = (&nonempty) && (!val_reg || i_data_rdy) && !(val_reg && last_reg);
                if (val_reg && last_reg && i_data_rdy)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output register and pixel counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            npix_reg <= '0;
            cnt_reg  <= '0;
            data_reg <= '0;
            val_reg  <= 1'b0;
            last_reg <= 1'b0;
        end else begin
            if (frame_start) begin
                npix_reg <= i_conf_npix;
                cnt_reg  <= '0;
            end
            if (pop) begin
                data_reg <= packed_word;
                val_reg  <= 1'b1;
                last_reg <= (cnt_inc == npix_reg);
                cnt_reg  <= cnt_inc;
            end else if (val_reg && i_data_rdy) begin
                val_reg  <= 1'b0;
                last_reg <= 1'b0;
            end
        end
    end

    assign o_data     = data_reg;
    assign o_data_val = val_reg;
    assign o_last     = last_reg;
    assign o_done     = (state_reg == DONE);
    assign o_busy     = (state_reg == RUN);
    assign o_overflow = overflow_reg;

endmodule

// File: tb/tb_ofmap_packer.sv
// Directed bench for ofmap_packer: expected words go into a queue when the
// stimulus is issued; a monitor pops and compares on each output handshake.
module tb_ofmap_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  kn0, kn1, kn2, kn3;
    logic        v0, v1, v2, v3;
    logic        i_start;
    logic [15:0] i_conf_npix;
    logic [31:0] o_data;
    logic        o_data_val;
    logic        i_data_rdy;
    logic        o_last;
    logic        o_done;
    logic        o_busy;
    logic [3:0]  o_overflow;

    int n_vec = 0;
    int n_err = 0;
    logic [32:0] exp_q [$];

    ofmap_packer dut (
        .clk(clk), .rst(rst),
        .i_psum_kn0(kn0), .i_psum_kn1(kn1), .i_psum_kn2(kn2), .i_psum_kn3(kn3),
        .i_psum_kn0_val(v0), .i_psum_kn1_val(v1), .i_psum_kn2_val(v2), .i_psum_kn3_val(v3),
        .i_start(i_start), .i_conf_npix(i_conf_npix),
        .o_data(o_data), .o_data_val(o_data_val), .i_data_rdy(i_data_rdy),
        .o_last(o_last), .o_done(o_done), .o_busy(o_busy), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", nm, act);
        end
    endtask

    task automatic set_in(input logic [3:0] m, input logic [31:0] d);
        kn0 = d[7:0];   kn1 = d[15:8];  kn2 = d[23:16]; kn3 = d[31:24];
        v0  = m[0];     v1  = m[1];     v2  = m[2];     v3  = m[3];
    endtask

    task automatic nclk();
        @(negedge clk);
    endtask

    task automatic start_frame(input logic [15:0] n);
        nclk();
        i_start = 1'b1;
        i_conf_npix = n;
        nclk();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        logic seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            nclk();
            if (o_done) seen = 1'b1;
        end
        chk(nm, {63'd0, seen}, 64'd1);
    endtask

    // Monitor: every handshake must match the head of the expectation queue.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (o_data_val && i_data_rdy) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: got 0x%0h last=%0b expected none", o_data, o_last);
                end else begin
                    e = exp_q.pop_front();
                    chk("word", {31'd0, o_last, o_data}, {31'd0, e});
                end
            end
        end
    end

    initial begin
        logic [31:0] w;
        rst = 1'b1;
        i_start = 1'b0;
        i_conf_npix = '0;
        i_data_rdy = 1'b1;
        set_in(4'b0000, 32'h0);
        repeat (3) nclk();
        rst = 1'b0;
        nclk();
        chk("reset_outputs", {o_data, o_data_val, o_last, o_done, o_busy, o_overflow}, 64'd0);

        // Frame of 3 words, all kernels streaming, consumer always ready.
        start_frame(16'd3);
        chk("busy_in_run", {63'd0, o_busy}, 64'd1);
        exp_q.push_back({1'b0, 32'h04030201});
        exp_q.push_back({1'b0, 32'h14131211});
        exp_q.push_back({1'b1, 32'h24232221});
        set_in(4'b1111, 32'h04030201);
        nclk();
        chk("latency_not_yet", {63'd0, o_data_val}, 64'd0);
        set_in(4'b1111, 32'h14131211);
        nclk();
        chk("latency_2", {63'd0, o_data_val}, 64'd1);
        set_in(4'b1111, 32'h24232221);
        nclk();
        set_in(4'b0000, 32'h0);
        nclk();
        chk("last_flag", {62'd0, o_last, o_done}, 64'd2);
        nclk();
        chk("done_pulse", {62'd0, o_done, o_busy}, 64'd2);
        nclk();
        chk("done_one_cycle", {63'd0, o_done}, 64'd0);

        // Skewed arrival: kn2 comes three cycles late.
        start_frame(16'd1);
        exp_q.push_back({1'b1, 32'hA4A3A2A1});
        set_in(4'b1011, 32'hA4A3A2A1);
        nclk();
        set_in(4'b0000, 32'h0);
        chk("skew_wait1", {63'd0, o_data_val}, 64'd0);
        nclk();
        chk("skew_wait2", {63'd0, o_data_val}, 64'd0);
        nclk();
        chk("skew_wait3", {63'd0, o_data_val}, 64'd0);
        set_in(4'b0100, 32'h00A30000);
        nclk();
        set_in(4'b0000, 32'h0);
        chk("skew_wait4", {63'd0, o_data_val}, 64'd0);
        nclk();
        chk("skew_word_val", {63'd0, o_data_val}, 64'd1);
        wait_done("skew_done", 5);

        // Back-pressure: 6 vectors with consumer stalled.
        start_frame(16'd5);
        i_data_rdy = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            w = 32'h40404040 + i * 32'h01010101;
            if (i <= 5) exp_q.push_back({(i == 5), w});
            set_in(4'b1111, w);
            nclk();
            if (i == 3) chk("stall_stable_a", {31'd0, o_data_val, o_data}, {31'd0, 1'b1, 32'h41414141});
            if (i == 5) chk("no_overflow_yet", {60'd0, o_overflow}, 64'd0);
        end
        set_in(4'b0000, 32'h0);
        chk("stall_stable_b", {30'd0, o_data_val, o_last, o_data}, {30'd0, 2'b10, 32'h41414141});
        chk("overflow_set", {60'd0, o_overflow}, 64'hF);
        nclk();
        i_data_rdy = 1'b1;
        wait_done("bp_done", 20);
        chk("overflow_sticky", {60'd0, o_overflow}, 64'hF);

        // npix = 0: immediate done, no words, overflow cleared by the start.
        start_frame(16'd0);
        chk("npix0_done", {61'd0, o_done, o_data_val, o_busy}, 64'd4);
        chk("overflow_cleared", {60'd0, o_overflow}, 64'd0);
        nclk();
        chk("npix0_idle", {62'd0, o_done, o_data_val}, 64'd0);

        // Reset mid-frame after 2 of 4 words, with a partial psum buffered.
        start_frame(16'd4);
        exp_q.push_back({1'b0, 32'h53525150});
        exp_q.push_back({1'b0, 32'h63626160});
        set_in(4'b1111, 32'h53525150);
        nclk();
        set_in(4'b1111, 32'h63626160);
        nclk();
        set_in(4'b0001, 32'h000000EE);
        nclk();
        set_in(4'b0000, 32'h0);
        nclk();
        nclk();
        rst = 1'b1;
        #1;
        chk("midframe_reset", {o_data, o_data_val, o_last, o_done, o_busy, o_overflow}, 64'd0);
        nclk();
        rst = 1'b0;
        start_frame(16'd1);
        exp_q.push_back({1'b1, 32'h77665544});
        set_in(4'b1111, 32'h77665544);
        nclk();
        set_in(4'b0000, 32'h0);
        wait_done("post_reset_done", 6);

        // Clamp behaviour depends on the build.
        start_frame(16'd1);
`ifdef OFMAP_PACKER_RELU_EN
        exp_q.push_back({1'b1, 32'h00007F00});
`else
        exp_q.push_back({1'b1, 32'h00FF7F80});
`endif
        set_in(4'b1111, 32'h00FF7F80);
        nclk();
        set_in(4'b0000, 32'h0);
        wait_done("relu_done", 6);

        repeat (3) nclk();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
